// File: rtl/dac_spi_tx.sv
// Serial transmitter for a 16-bit SPI DAC frame {2'b00, PD_MODE, data}, MSB first.
// A single frame is sent per accepted start, followed by a quiet gap with sync_n high.
module dac_spi_tx #(
  parameter int unsigned CLK_DIV   = 2,
  parameter int unsigned QUIET_CYC = 4,
  parameter logic [1:0]  PD_MODE   = 2'b00
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [11:0] data_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        sync_n_o,
  output logic        sclk_o,
  output logic        sdata_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    QUIET = 2'd3
  } state_t;

  localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);
  localparam logic [7:0] QUIET_LAST = 8'(QUIET_CYC - 1);

  state_t      state_reg, state_next;
  logic [7:0]  half_cnt_reg, half_cnt_next;
  logic [4:0]  bit_cnt_reg, bit_cnt_next;
  logic [15:0] frame_reg, frame_next;
  logic        sclk_reg, sclk_next;
  logic        sync_n_reg, sync_n_next;
  logic        busy_reg, busy_next;
  logic        done_reg, done_next;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg    <= IDLE;
      half_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      frame_reg    <= '0;
      sclk_reg     <= 1'b1;
      sync_n_reg   <= 1'b1;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      half_cnt_reg <= half_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      frame_reg    <= frame_next;
      sclk_reg     <= sclk_next;
      sync_n_reg   <= sync_n_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    half_cnt_next = half_cnt_reg;
    bit_cnt_next  = bit_cnt_reg;
    frame_next    = frame_reg;
    sclk_next     = sclk_reg;
    sync_n_next   = sync_n_reg;
    busy_next     = busy_reg;
    done_next     = 1'b0;

    case (state_reg)
      IDLE: begin
        busy_next   = 1'b0;
        sync_n_next = 1'b1;
        sclk_next   = 1'b1;
        if (start_i) begin
          frame_next    = {2'b00, PD_MODE, data_i};
          busy_next     = 1'b1;
          sync_n_next   = 1'b0;
          half_cnt_next = '0;
          bit_cnt_next  = '0;
          state_next    = SETUP;
        end
      end

      SETUP: begin
        if (half_cnt_reg == DIV_LAST) begin
          half_cnt_next = '0;
          sclk_next     = 1'b0;
          state_next    = SHIFT;
        end else begin
          half_cnt_next = half_cnt_reg + 8'd1;
        end
      end

      // bit_cnt tracks the half-period index; data advances only on sclk rising.
      SHIFT: begin
        if (half_cnt_reg == DIV_LAST) begin
          half_cnt_next = '0;
          if (bit_cnt_reg == 5'd31) begin
            state_next  = QUIET;
            sync_n_next = 1'b1;
            sclk_next   = 1'b1;
            frame_next  = '0;
            done_next   = (QUIET_LAST == 8'd0);
          end else begin
            bit_cnt_next = bit_cnt_reg + 5'd1;
            if (!bit_cnt_reg[0]) begin
              sclk_next  = 1'b1;
              frame_next = {frame_reg[14:0], 1'b0};
            end else begin
              sclk_next = 1'b0;
            end
          end
        end else begin
          half_cnt_next = half_cnt_reg + 8'd1;
        end
      end

      QUIET: begin
        if (done_reg) begin
          state_next    = IDLE;
          busy_next     = 1'b0;
          half_cnt_next = '0;
          bit_cnt_next  = '0;
        end else begin
          half_cnt_next = half_cnt_reg + 8'd1;
          done_next     = ((half_cnt_reg + 8'd1) == QUIET_LAST);
        end
      end

      default: begin
        state_next    = IDLE;
        half_cnt_next = '0;
        bit_cnt_next  = '0;
        frame_next    = '0;
        sclk_next     = 1'b1;
        sync_n_next   = 1'b1;
        busy_next     = 1'b0;
      end
    endcase
  end

  assign busy_o   = busy_reg;
  assign done_o   = done_reg;
  assign sync_n_o = sync_n_reg;
  assign sclk_o   = sclk_reg;
  assign sdata_o  = frame_reg[15];

endmodule

// File: tb/tb_dac_spi_tx.sv
// Bench for dac_spi_tx: two instances (CLK_DIV=2/PD=00 and CLK_DIV=1/PD=11) are traced
// cycle by cycle, and frames are decoded from the trace like a DAC would see them.
module tb_dac_spi_tx;

  logic        clk;
  logic        rst;
  logic        start;
  logic        cur_sel;
  logic [11:0] data;

  logic busy0, done0, sync0, sclk0, sdata0;
  logic busy1, done1, sync1, sclk1, sdata1;
  logic start0, start1;

  assign start0 = start & ~cur_sel;
  assign start1 = start &  cur_sel;

  dac_spi_tx #(.CLK_DIV(2), .QUIET_CYC(4), .PD_MODE(2'b00)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .start_i(start0), .data_i(data),
    .busy_o(busy0), .done_o(done0), .sync_n_o(sync0), .sclk_o(sclk0), .sdata_o(sdata0)
  );

  dac_spi_tx #(.CLK_DIV(1), .QUIET_CYC(4), .PD_MODE(2'b11)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start1), .data_i(data),
    .busy_o(busy1), .done_o(done1), .sync_n_o(sync1), .sclk_o(sclk1), .sdata_o(sdata1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Trace entry layout: {busy, done, sync_n, sclk, sdata}
  localparam logic [4:0] IDLE_OUT = 5'b00110;
  logic [4:0] tr0[$];
  logic [4:0] tr1[$];

  always @(posedge clk) begin
    #1;
    tr0.push_back({busy0, done0, sync0, sclk0, sdata0});
    tr1.push_back({busy1, done1, sync1, sclk1, sdata1});
  end

  typedef struct {
    int          start;
    int          len;
    int          falls;
    logic [15:0] bits;
    bit          stable;
  } frame_t;

  frame_t frames[$];
  int     dones[$];

  int chk_cnt  = 0;
  int pass_cnt = 0;

  function automatic logic [4:0] trace_at(input bit sel, input int i);
    return sel ? tr1[i] : tr0[i];
  endfunction

  // Splits the trace into sync_n-low frames and shifts in sdata at every sclk fall.
  function automatic void decode(input bit sel, input int lo, input int hi);
    logic [4:0] c;
    logic [4:0] p;
    bit         in_f;
    frame_t     f;
    frames.delete();
    dones.delete();
    in_f = 1'b0;
    f = '{0, 0, 0, 16'h0, 1'b1};
    for (int i = lo; i < hi; i++) begin
      c = trace_at(sel, i);
      p = (i > 0) ? trace_at(sel, i - 1) : IDLE_OUT;
      if (!c[2]) begin
        if (!in_f) begin
          in_f = 1'b1;
          f = '{i, 0, 0, 16'h0, 1'b1};
        end
        f.len++;
        if (i > f.start && p[1] && !c[1]) begin
          f.falls++;
          f.bits = {f.bits[14:0], c[0]};
          if (p[0] != c[0]) f.stable = 1'b0;
        end
      end else if (in_f) begin
        frames.push_back(f);
        in_f = 1'b0;
      end
      if (c[3]) dones.push_back(i);
    end
    if (in_f) frames.push_back(f);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // One start pulse; expectations come from the caller (table or model).
  task automatic run_one(input bit sel, input logic [11:0] d, input bit scr,
                         input logic [15:0] ef, input int elen, input int edone);
    int         acc;
    logic [4:0] a;
    @(negedge clk);
    cur_sel = sel;
    data    = d;
    start   = 1'b1;
    acc     = tr0.size();
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < edone + 8; k++) begin
      @(negedge clk);
      if (scr) data = 12'($urandom);
    end
    decode(sel, acc, acc + edone + 8);
    a = trace_at(sel, acc);
    check("busy_after_accept", 32'(a[4]), 32'd1);
    check("sclk_after_accept", 32'(a[1]), 32'd1);
    check("sdata_bit15", 32'(a[0]), 32'(ef[15]));
    check("frame_count", 32'(frames.size()), 32'd1);
    if (frames.size() > 0) begin
      check("sync_first_low", 32'(frames[0].start - acc), 32'd0);
      check("sync_low_len", 32'(frames[0].len), 32'(elen));
      check("sclk_falls", 32'(frames[0].falls), 32'd16);
      check("frame_bits", 32'(frames[0].bits), 32'(ef));
      check("sdata_stable", 32'(frames[0].stable), 32'd1);
    end
    check("done_count", 32'(dones.size()), 32'd1);
    if (dones.size() > 0) begin
      check("done_latency", 32'(dones[0] - acc + 1), 32'(edone));
      a = trace_at(sel, dones[0]);
      check("busy_in_done", 32'(a[4]), 32'd1);
      a = trace_at(sel, dones[0] + 1);
      check("busy_after_done", 32'(a[4]), 32'd0);
    end
    $display("frame dut%0d data=%03h scramble=%0d captured=%04h expect=%04h",
             sel, d, scr, (frames.size() > 0) ? frames[0].bits : 16'h0, ef);
  endtask

  typedef struct {
    bit          sel;
    logic [11:0] data;
    bit          scr;
    logic [15:0] frame;
    int          len;
    int          done_lat;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int          acc;
    int          bad;
    bit          sel;
    bit          scr;
    logic [11:0] d;
    logic [15:0] ef;
    int          cd;

    vecs[0] = '{1'b0, 12'hABC, 1'b0, 16'h0ABC, 66, 70};
    vecs[1] = '{1'b0, 12'h000, 1'b0, 16'h0000, 66, 70};
    vecs[2] = '{1'b0, 12'hFFF, 1'b0, 16'h0FFF, 66, 70};
    vecs[3] = '{1'b0, 12'h800, 1'b0, 16'h0800, 66, 70};
    vecs[4] = '{1'b1, 12'h5A5, 1'b0, 16'h35A5, 33, 37};
    vecs[5] = '{1'b0, 12'h3C7, 1'b1, 16'h03C7, 66, 70};
    vecs[6] = '{1'b1, 12'h001, 1'b1, 16'h3001, 33, 37};

    rst = 1'b1; start = 1'b0; cur_sel = 1'b0; data = 12'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_idle_dut0", 32'(tr0[tr0.size() - 1]), 32'(IDLE_OUT));
    check("reset_idle_dut1", 32'(tr1[tr1.size() - 1]), 32'(IDLE_OUT));

    foreach (vecs[i])
      run_one(vecs[i].sel, vecs[i].data, vecs[i].scr, vecs[i].frame, vecs[i].len, vecs[i].done_lat);

    // Model: frame = {00, PD, data}; sync low 33*CLK_DIV cycles; done QUIET_CYC later.
    for (int n = 0; n < 8; n++) begin
      sel = 1'($urandom_range(0, 1));
      scr = 1'($urandom_range(0, 1));
      d   = 12'($urandom);
      cd  = sel ? 1 : 2;
      ef  = {2'b00, (sel ? 2'b11 : 2'b00), d};
      run_one(sel, d, scr, ef, 33 * cd, 33 * cd + 4);
    end

    // Back-to-back with start held high.
    @(negedge clk);
    cur_sel = 1'b0; data = 12'h001; start = 1'b1;
    acc = tr0.size();
    @(negedge clk);
    data = 12'hFFF;
    repeat (74) @(negedge clk);
    start = 1'b0;
    repeat (80) @(negedge clk);
    decode(1'b0, acc, acc + 155);
    check("b2b_frame_count", 32'(frames.size()), 32'd2);
    check("b2b_done_count", 32'(dones.size()), 32'd2);
    if (frames.size() == 2) begin
      check("b2b_first_bits", 32'(frames[0].bits), 32'h0001);
      check("b2b_second_bits", 32'(frames[1].bits), 32'h0FFF);
      check("b2b_gap", 32'(frames[1].start - (frames[0].start + frames[0].len)), 32'd5);
      check("b2b_idle_busy", 32'(trace_at(1'b0, frames[1].start - 1) >> 4), 32'd0);
    end
    $display("back-to-back frames=%0d dones=%0d", frames.size(), dones.size());

    // Reset asserted in cycle 20 of a frame.
    @(negedge clk);
    cur_sel = 1'b0; data = 12'hABC; start = 1'b1;
    acc = tr0.size();
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (80) @(negedge clk);
    decode(1'b0, acc, acc + 100);
    check("abort_outputs", 32'(tr0[acc + 20]), 32'(IDLE_OUT));
    check("abort_no_done", 32'(dones.size()), 32'd0);
    check("abort_frame_count", 32'(frames.size()), 32'd1);
    if (frames.size() > 0) check("abort_low_len", 32'(frames[0].len), 32'd20);
    bad = 0;
    for (int i = acc + 20; i < acc + 100; i++)
      if (tr0[i] !== IDLE_OUT) bad++;
    check("abort_idle_hold", 32'(bad), 32'd0);
    $display("reset mid-frame low=%0d dones=%0d", (frames.size() > 0) ? frames[0].len : 0, dones.size());
    run_one(1'b0, 12'h123, 1'b0, 16'h0123, 66, 70);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
